// File: rtl/matrix_unloader.sv
// Serializes a captured 2x2 multiplier result as row-major R x C words; optional header under UNLOADER_HEADER_EN.
// First word one cycle after capture (two with header); words hold while out_ready is low and advance only on transfer.
module matrix_unloader #(
   parameter int ELEM_W  = 16,
   parameter int MAX_DIM = 2
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [4*ELEM_W-1:0] res_mat,
   input  logic                res_valid,
   input  logic [3:0]          rows,
   input  logic [3:0]          cols,
   output logic [ELEM_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy,
   output logic                dim_err,
   output logic [7:0]          drop_cnt
);

   localparam logic [3:0] DMAX = 4'(MAX_DIM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1
`ifdef UNLOADER_HEADER_EN
      ,HDR = 2'd2
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [4*ELEM_W-1:0]   hold_q, hold_d;
   logic [3:0]            n_q, n_d;
   logic                  two_q, two_d;
   logic [3:0]            idx_q, idx_d;
   logic [ELEM_W-1:0]     data_d;
   logic                  vld_d, last_d, err_d;
   logic [7:0]            drop_d;

   logic [3:0]            rows_cl, cols_cl, n_cap;
   logic                  bad_dims, xfer, capture;

   function automatic logic [ELEM_W-1:0] pick(input logic [4*ELEM_W-1:0] m, input logic [1:0] e);
      case (e)
         2'd0:    return m[4*ELEM_W-1 -: ELEM_W];
         2'd1:    return m[3*ELEM_W-1 -: ELEM_W];
         2'd2:    return m[2*ELEM_W-1 -: ELEM_W];
         default: return m[ELEM_W-1:0];
      endcase
   endfunction

   // Sequence position to element index: a single column skips to the next row.
   function automatic logic [1:0] seq_elem(input logic [1:0] k, input logic two_cols);
      return two_cols ? k : {k[0], 1'b0};
   endfunction

   always_comb begin
      rows_cl  = rows;
      cols_cl  = cols;
      if (rows == 4'd0 || rows > DMAX) rows_cl = DMAX;
      if (cols == 4'd0 || cols > DMAX) cols_cl = DMAX;
      bad_dims = (rows_cl != rows) || (cols_cl != cols);
      n_cap    = rows_cl * cols_cl;

      xfer     = out_valid && out_ready;
      capture  = 1'b0;
      state_d  = state_q;
      hold_d   = hold_q;
      n_d      = n_q;
      two_d    = two_q;
      idx_d    = idx_q;
      data_d   = out_data;
      vld_d    = out_valid;
      last_d   = out_last;
      err_d    = dim_err;
      drop_d   = drop_cnt;

      case (state_q)
         IDLE: capture = res_valid;
`ifdef UNLOADER_HEADER_EN
         HDR: begin
            if (xfer) begin
               state_d = SEND;
               idx_d   = 4'd0;
               data_d  = pick(hold_q, 2'd0);
               last_d  = (n_q == 4'd1);
            end
         end
`endif
         SEND: begin
            if (xfer) begin
               if (out_last) begin
                  if (res_valid) begin
                     capture = 1'b1;
                  end else begin
                     state_d = IDLE;
                     vld_d   = 1'b0;
                     last_d  = 1'b0;
                     data_d  = '0;
                  end
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = pick(hold_q, seq_elem(idx_d[1:0], two_q));
                  last_d = (idx_q + 4'd2 == n_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && res_valid && !capture && drop_cnt != 8'hFF)
         drop_d = drop_cnt + 8'd1;

      if (capture) begin
         hold_d = res_mat;
         n_d    = n_cap;
         two_d  = (cols_cl == 4'd2);
         idx_d  = 4'd0;
         err_d  = dim_err | bad_dims;
         vld_d  = 1'b1;
`ifdef UNLOADER_HEADER_EN
         state_d = HDR;
         data_d  = ELEM_W'({rows_cl, cols_cl, 4'd0, n_cap});
         last_d  = 1'b0;
`else
         state_d = SEND;
         data_d  = pick(res_mat, 2'd0);
         last_d  = (n_cap == 4'd1);
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         n_q       <= '0;
         two_q     <= 1'b0;
         idx_q     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         dim_err   <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         n_q       <= n_d;
         two_q     <= two_d;
         idx_q     <= idx_d;
         out_data  <= data_d;
         out_valid <= vld_d;
         out_last  <= last_d;
         dim_err   <= err_d;
         drop_cnt  <= drop_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_unloader.sv
// Scoreboard bench for matrix_unloader: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_matrix_unloader;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic [63:0] res_mat = '0;
   logic        res_valid = 1'b0;
   logic [3:0]  rows = 4'd1;
   logic [3:0]  cols = 4'd1;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        busy;
   logic        dim_err;
   logic [7:0]  drop_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [16:0] sb[$];
   int          exp_drop = 0;
   logic        exp_err = 1'b0;

   matrix_unloader dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .res_mat   (res_mat),
      .res_valid (res_valid),
      .rows      (rows),
      .cols      (cols),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .dim_err   (dim_err),
      .drop_cnt  (drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: clamp dims, then walk the R x C sub-block row-major.
   task automatic push_result(input logic [63:0] m, input logic [3:0] r, input logic [3:0] c);
      int rc, cc;
      logic [15:0] w;
      rc = (r == 0 || r > 2) ? 2 : int'(r);
      cc = (c == 0 || c > 2) ? 2 : int'(c);
      if (rc != int'(r) || cc != int'(c)) exp_err = 1'b1;
`ifdef UNLOADER_HEADER_EN
      sb.push_back({1'b0, 4'(rc), 4'(cc), 8'(rc * cc)});
`endif
      for (int i = 0; i < rc; i++) begin
         for (int j = 0; j < cc; j++) begin
            w = m[63 - 16 * (2 * i + j) -: 16];
            sb.push_back({(i == rc - 1 && j == cc - 1), w});
         end
      end
   endtask

   // Drives one cycle's inputs at posedge+1 and updates the model at the following edge.
   task automatic step(input logic rv, input logic [63:0] m, input logic [3:0] r,
                       input logic [3:0] c, input logic rdy);
      logic xfer_pred, acc;
      res_valid = rv;
      res_mat   = m;
      rows      = r;
      cols      = c;
      out_ready = rdy;
      xfer_pred = (sb.size() > 0) && rdy;
      acc       = rv && (sb.size() == 0 || (sb.size() == 1 && xfer_pred));
      @(posedge CLK);
      if (acc) push_result(m, r, c);
      else if (rv && exp_drop != 255) exp_drop++;
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, rnd64(), 4'($urandom), 4'($urandom), 1'b1);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() > 0 && guard < 60) begin
         step(1'b0, rnd64(), 4'($urandom), 4'($urandom), 1'b1);
         guard++;
      end
      checks++;
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain_timeout remaining=%0d required=0", sb.size());
         sb.delete();
      end
      idle(2);
   endtask

   task automatic do_reset();
      RST_N     = 1'b0;
      res_valid = 1'b0;
      #2;
      chk("rst_out_data", out_data, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dim_err", dim_err, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      sb.delete();
      exp_drop = 0;
      exp_err  = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   initial begin : monitor
      logic        prev_stall;
      logic [16:0] prev_word;
      logic [16:0] w;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            prev_stall = 1'b0;
         end else begin
            chk("out_valid", out_valid, sb.size() > 0);
            chk("busy", busy, sb.size() > 0);
            if (prev_stall) chk("stall_hold", {out_last, out_data}, prev_word);
            if (out_valid && out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL spurious_xfer actual=%0h required=none", {out_last, out_data});
               end else begin
                  w = sb.pop_front();
                  if ({out_last, out_data} !== w) begin
                     failures++;
                     $display("FAIL word actual=%0h required=%0h at %0t", {out_last, out_data}, w, $time);
                  end
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
         end
      end
   end

   initial begin : stimulus
      logic rp[4];
      int   guard;
      rp = '{1'b1, 1'b0, 1'b0, 1'b1};
      #1;
      do_reset();
      idle(2);

      // Directed 2x2 and 2x1 results.
      step(1'b1, 64'h0001_0002_0003_0004, 4'd2, 4'd2, 1'b1);
      drain();
      step(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 4'd2, 4'd1, 1'b1);
      drain();
      step(1'b1, 64'h1111_2222_3333_4444, 4'd1, 4'd2, 1'b1);
      drain();

      // Stalls with out_ready 1,0,0,1,...
      step(1'b1, 64'h0A0B_0C0D_0E0F_1011, 4'd2, 4'd2, 1'b1);
      guard = 0;
      while (sb.size() > 0 && guard < 40) begin
         step(1'b0, rnd64(), 4'd2, 4'd2, rp[guard % 4]);
         guard++;
      end
      drain();

      // Strobe during word 1 of 4 is dropped.
      step(1'b1, 64'h5555_6666_7777_8888, 4'd2, 4'd2, 1'b1);
      step(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 4'd1, 4'd1, 1'b1);
      drain();
      chk("drop_one", drop_cnt, exp_drop);

      // Saturation of the drop counter.
      step(1'b1, 64'h9999_8888_7777_6666, 4'd2, 4'd2, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b1, rnd64(), 4'd1, 4'd1, 1'b0);
      chk("drop_sat", drop_cnt, exp_drop);
      drain();

      // Back-to-back: new result coincident with the final transfer.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, rnd64(), 4'd2, 4'd2, 1'b1);
         guard = 0;
         while (sb.size() > 1 && guard < 20) begin
            step(1'b0, rnd64(), 4'd2, 4'd2, 1'b1);
            guard++;
         end
      end
      step(1'b1, 64'h0102_0304_0506_0708, 4'd2, 4'd2, 1'b1);
      drain();

      // Illegal dims clamp to 2x2 and set the sticky error.
      step(1'b1, 64'hF00D_CAFE_BABE_FACE, 4'd0, 4'd3, 1'b1);
      drain();
      chk("dim_err_set", dim_err, exp_err);
      step(1'b1, 64'h1234_5678_9ABC_DEF0, 4'd1, 4'd1, 1'b1);
      drain();
      chk("dim_err_sticky", dim_err, exp_err);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, rnd64(),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 2)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 2)),
              $urandom_range(0, 3) != 0);
      end
      drain();
      chk("rand_drop_cnt", drop_cnt, exp_drop);
      chk("rand_dim_err", dim_err, exp_err);

      // Reset mid-stream aborts the stream.
      step(1'b1, 64'h4444_3333_2222_1111, 4'd2, 4'd2, 1'b1);
      step(1'b0, rnd64(), 4'd2, 4'd2, 1'b0);
      do_reset();
      idle(3);
      step(1'b1, 64'h7777_0000_0000_0000, 4'd1, 4'd1, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
